// File: rtl/mlu_seq.sv
// Nibble-serial ALU sequencer: drives one external combinational 4-bit slice
// over WIDTH/4 passes, LSB nibble first, and accumulates RESULT/CARRY/ZERO.
package common;
  typedef enum logic [2:0] {
    MLU_ADD  = 3'd0,
    MLU_SUB  = 3'd1,
    MLU_AND  = 3'd2,
    MLU_OR   = 3'd3,
    MLU_XOR  = 3'd4,
    MLU_NOT  = 3'd5,
    MLU_NOP0 = 3'd6,
    MLU_NOP1 = 3'd7
  } mlu_op_e;
endpackage

module mlu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [11:0]      slice_addr,
  input  logic [7:0]       slice_out,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state, state_nx;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             accept, last_pass, is_arith;
  logic             slice_prop, slice_gen, slice_zero, slice_unused;

  assign accept       = (state == S_IDLE) && start;
  assign last_pass    = (idx == IW'(NIB - 1));
  assign is_arith     = (op_q == common::MLU_ADD) || (op_q == common::MLU_SUB);
  assign slice_prop   = slice_out[4];
  assign slice_gen    = slice_out[5];
  assign slice_zero   = slice_out[6];
  assign slice_unused = slice_out[7];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    slice_addr = '0;
    unique case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        busy       = 1'b1;
        slice_addr = {carry, op_q, b_q[4*idx +: 4], a_q[4*idx +: 4]};
        if (last_pass) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: latched operands are reset too, so an aborted operation leaves no stale data behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      a_q   <= a;
      b_q   <= b;
      op_q  <= op;
      carry <= (op == common::MLU_SUB);
      zero  <= 1'b1;
    end else if (state == S_RUN) begin
      result[4*idx +: 4] <= slice_out[3:0];
      idx                <= idx + 1'b1;
      // Only ADD/SUB ripple a carry between nibbles; logic ops end with CARRY 0.
      carry              <= is_arith ? (slice_gen | (slice_prop & carry)) : 1'b0;
      zero               <= zero & slice_zero;
    end
  end

endmodule

// File: tb/tb_mlu_seq.sv
// Self-checking bench for mlu_seq: behavioural slice, word-level reference
// model, per-cycle compare process, directed literal cases and random traffic.
module tb_mlu_seq;
  import common::*;

  localparam int WIDTH = 32;
  localparam int NIB   = WIDTH / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, carry, zero;
  logic [11:0] slice_addr;
  logic [7:0]  slice_out;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  mlu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .slice_addr(slice_addr), .slice_out(slice_out),
    .result(result), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural 4-bit slice.
  logic [3:0] s_a, s_b, s_sum;
  logic [2:0] s_op;
  logic       s_ci, s_p, s_g;
  logic [4:0] s_t;
  always_comb begin
    s_a = slice_addr[3:0];
    s_b = slice_addr[7:4];
    s_op = slice_addr[10:8];
    s_ci = slice_addr[11];
    s_t = '0;
    s_sum = '0;
    s_p = 1'b0;
    s_g = 1'b0;
    case (s_op)
      MLU_ADD: begin s_t = {1'b0, s_a} + {1'b0, s_b};  s_sum = s_a + s_b + {3'b0, s_ci};  end
      MLU_SUB: begin s_t = {1'b0, s_a} + {1'b0, ~s_b}; s_sum = s_a + ~s_b + {3'b0, s_ci}; end
      MLU_AND: s_sum = s_a & s_b;
      MLU_OR:  s_sum = s_a | s_b;
      MLU_XOR: s_sum = s_a ^ s_b;
      MLU_NOT: s_sum = ~s_a;
      default: s_sum = '0;
    endcase
    if (s_op == MLU_ADD || s_op == MLU_SUB) begin
      s_g = s_t[4];
      s_p = (s_t[3:0] == 4'hF);
    end
    slice_out = {1'b0, (s_sum == 4'h0), s_g, s_p, s_sum};
  end

  // Word-level reference: returns {zero, carry, result}.
  function automatic logic [33:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    case (o)
      MLU_ADD: s = {1'b0, x} + {1'b0, y};
      MLU_SUB: s = {1'b0, x} + {1'b0, ~y} + 33'd1;
      MLU_AND: s = {1'b0, x & y};
      MLU_OR:  s = {1'b0, x | y};
      MLU_XOR: s = {1'b0, x ^ y};
      MLU_NOT: s = {1'b0, ~x};
      default: s = '0;
    endcase
    return {(s[31:0] == 32'h0), s[32], s[31:0]};
  endfunction

  // Carry entering nibble i, from the sum of the lower 4*i bits.
  function automatic logic carry_into(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int i);
    logic [63:0] m, xx, yy, s;
    m  = (64'd1 << (4 * i)) - 64'd1;
    xx = {32'b0, x} & m;
    if (o == MLU_ADD)      begin yy = {32'b0, y} & m;  s = xx + yy;         end
    else if (o == MLU_SUB) begin yy = {32'b0, ~y} & m; s = xx + yy + 64'd1; end
    else return 1'b0;
    return s[4*i];
  endfunction

  // Timing model: an accepted op is busy for NIB cycles, then DONE for one,
  // and a new accept needs one idle edge after DONE.
  int          cyc = 0;
  int          acc = -100;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [33:0] m_exp = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= -100;
      m_exp <= '0;
    end else begin
      cyc <= cyc + 1;
      if (start && (cyc + 1 >= acc + NIB + 2)) begin
        acc   <= cyc + 1;
        m_op  <= op;
        m_a   <= a;
        m_b   <= b;
        m_exp <= ref_op(op, a, b);
      end
    end
  end

  always @(negedge clk) begin : cmp
    int k;
    k = cyc - acc;
    if (k >= 0 && k < NIB) begin
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("slice_addr", slice_addr,
            {carry_into(m_op, m_a, m_b, k), m_op, m_b[4*k +: 4], m_a[4*k +: 4]});
    end else begin
      check("busy_idle", busy, 0);
      check("done_pulse", done, (k == NIB));
      check("slice_addr_idle", slice_addr, 0);
      check("result", result, m_exp[31:0]);
      check("carry", carry, m_exp[32]);
      check("zero", zero, m_exp[33]);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", (n < 40), 1);
  endtask

  // Launches one op; optionally pulses START at edges T+3 and T+9.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit extra, output int lat, output logic [11:0] first_addr);
    wait_idle();
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    first_addr = slice_addr;
    a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = extra && (lat == 2);
      if (done) break;
    end
    if (extra) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  int          lat, dones;
  logic [11:0] fa;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    rst = 1'b0;

    run_op(MLU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0, lat, fa);
    check("lat_add", lat, NIB);
    check("add_ovf_result", result, 32'h0);
    check("add_ovf_carry", carry, 1);
    check("add_ovf_zero", zero, 1);

    run_op(MLU_SUB, 32'd5, 32'd7, 0, lat, fa);
    check("sub57_result", result, 32'hFFFF_FFFE);
    check("sub57_carry", carry, 0);
    check("sub57_zero", zero, 0);

    run_op(MLU_SUB, 32'd7, 32'd7, 0, lat, fa);
    check("sub77_first_cin", fa[11], 1);
    check("sub77_result", result, 32'h0);
    check("sub77_carry", carry, 1);
    check("sub77_zero", zero, 1);

    run_op(MLU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, lat, fa);
    check("and_result", result, 32'hF000_F000);
    check("and_carry", carry, 0);

    run_op(MLU_NOT, 32'h0000_FFFF, 32'h1234_5678, 0, lat, fa);
    check("not_result", result, 32'hFFFF_0000);

    run_op(MLU_ADD, 32'h1234_5678, 32'h1111_1111, 0, lat, fa);
    check("add_first_addr_lo", fa[7:0], 8'h18);
    check("add_first_addr_cin", fa[11], 0);
    check("add_result", result, 32'h2345_6789);

    run_op(MLU_NOP0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, lat, fa);
    check("nop_result", result, 32'h0);
    check("nop_carry", carry, 0);
    check("nop_zero", zero, 1);

    run_op(MLU_ADD, 32'h0000_1000, 32'h0000_0234, 1, lat, fa);
    check("ignore_start_lat", lat, NIB);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ignore_start_dones", dones, 0);
    check("ignore_start_result", result, 32'h0000_1234);

    // Asynchronous reset during pass 4.
    wait_idle();
    op = MLU_ADD; a = 32'h8765_4321; b = 32'h1111_1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_carry", carry, 0);
    check("arst_zero", zero, 0);
    check("arst_slice_addr", slice_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("arst_no_done", dones, 0);
    run_op(MLU_ADD, 32'd2, 32'd3, 0, lat, fa);
    check("post_rst_add", result, 32'd5);

    // Random traffic with occasional corner operands and rare resets.
    repeat (1500) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'h0;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      #1 rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mlu_seq.md
MLU_SEQ -- requirements
Module: mlu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of 4, giving NIB = WIDTH/4 slice passes.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high.
REQ-004 START  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 OP  input  3  operation code, one of common::MLU_ADD/SUB/AND/OR/XOR/NOT/NOP0/NOP1.
REQ-006 A, B  input  WIDTH each  operands.
REQ-007 BUSY  output  1  high while in RUN.
REQ-008 DONE  output  1  single-cycle pulse when RESULT/CARRY/ZERO are valid.
REQ-009 SLICE_ADDR  output  12  address to one 4-bit MLU slice: [3:0] A nibble, [7:4] B nibble, [10:8] OP, [11] carry-in.
REQ-010 SLICE_OUT  input  8  combinational slice response: [3:0] sum, [4] prop, [5] gen, [6] zero, [7] unused.
REQ-011 RESULT  output  WIDTH; CARRY  output  1; ZERO  output  1  registered final results.

Function
REQ-012 The block SHALL time-multiplex one slice across NIB passes, least-significant nibble first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; the only transitions SHALL be IDLE->RUN on START, RUN->DONE after pass NIB-1, DONE->IDLE unconditionally.
REQ-014 On accepting START, the block SHALL latch A, B and OP, clear nibble index to 0, and set the carry register to 1 for MLU_SUB, else 0.
REQ-015 In RUN, SLICE_ADDR SHALL be driven combinationally from registers: {carry, OP_latched, B_latched[4i+3:4i], A_latched[4i+3:4i]} for index i; in IDLE/DONE SLICE_ADDR SHALL be 0.
REQ-016 At each RUN edge, SLICE_OUT[3:0] SHALL be written to RESULT[4i+3:4i], and i SHALL increment.
REQ-017 At each RUN edge, the carry register SHALL update to gen | (prop & carry) for ADD/SUB, and to 0 for all other ops.
REQ-018 ZERO SHALL accumulate as AND of SLICE_OUT[6] over all passes; it SHALL be preset to 1 at accept.
REQ-019 CARRY SHALL equal the carry register after the final pass; for SUB, 1 means no borrow.
REQ-020 Latency: START sampled at edge T SHALL yield DONE high in the cycle after edge T+NIB (T+9 for WIDTH=32); BUSY SHALL be high for exactly NIB cycles.
REQ-021 START while in RUN or DONE SHALL be ignored, with no queuing.
REQ-022 Latched inputs SHALL be immune to A/B/OP changes after accept.
REQ-023 RESULT, CARRY and ZERO SHALL hold their values from DONE until the next accept; during RUN they MAY show partial values.
REQ-024 NOP0/NOP1 SHALL complete normally with RESULT 0, ZERO 1, CARRY 0.

Reset
REQ-025 RST high SHALL immediately force IDLE, BUSY 0, DONE 0, RESULT 0, CARRY 0, ZERO 0, nibble index 0, and latched operands 0, including when asserted mid-operation.
REQ-026 After RST deasserts, the first START SHALL be accepted normally; an aborted operation SHALL never produce DONE.

Verification
REQ-027 ADD A=0xFFFFFFFF, B=0x00000001 -> RESULT 0x00000000, CARRY 1, ZERO 1, DONE 9 cycles after START edge.
REQ-028 SUB A=5, B=7 -> RESULT 0xFFFFFFFE, CARRY 0, ZERO 0; SUB A=7, B=7 -> RESULT 0, CARRY 1, ZERO 1.
REQ-029 AND A=0xF0F0F0F0, B=0xFF00FF00 -> RESULT 0xF000F000, CARRY 0; NOT A=0x0000FFFF -> RESULT 0xFFFF0000.
REQ-030 ADD A=0x12345678, B=0x11111111 -> first-pass SLICE_ADDR low byte 0x18 with bit11=0; RESULT 0x23456789.
REQ-031 START pulsed again at cycles 3 and 9 of a running op -> both ignored; one DONE only, and RESULT matches the first op.
REQ-032 RST asserted in pass 4 -> all outputs 0 asynchronously, no DONE; subsequent ADD 2+3 -> RESULT 5.
